// File: rtl/cla_pipe_subtractor_pkg.sv
// Shared constants and the stage-register layout for the pipelined CLA subtractor.
package cla_pipe_subtractor_pkg;

  localparam int CLA_WIDTH   = 32;
  localparam int CLA_SLICE_W = 8;
  localparam int CLA_NSLICE  = CLA_WIDTH / CLA_SLICE_W;

  // One in-flight operation between slices.
  // diff_acc fills from the top down, one byte per stage, so it is fully
  // aligned when the last slice lands. a_rem/b_rem hold the operand bytes
  // still to be consumed, shifted so the next slice always reads bits [7:0].
  // b_rem already holds the inverted subtrahend.
  typedef struct packed {
    logic                 valid;
    logic                 carry;
    logic [CLA_WIDTH-1:0] diff_acc;
    logic [CLA_WIDTH-1:0] a_rem;
    logic [CLA_WIDTH-1:0] b_rem;
    logic                 a_msb;
    logic                 b_msb;
  } stage_t;

endpackage

// File: rtl/cla_slice8.sv
// Combinational 8-bit carry-lookahead adder slice with group propagate/generate.
module cla_slice8 (
  input  logic [7:0] x,
  input  logic [7:0] y,
  input  logic       cin,
  output logic [7:0] s,
  output logic       cout,
  output logic       group_p,
  output logic       group_g
);

  logic [7:0] g;
  logic [7:0] p;
  logic [8:0] c;
  logic       prop;
  logic       gen;

  assign g = x & y;
  assign p = x ^ y;

  // Every carry is formed directly from the bit generate/propagate terms and
  // cin (no ripple): c[i+1] = g[i] | p[i]g[i-1] | ... | p[i..0]cin.
  always_comb begin
    c       = '0;
    c[0]    = cin;
    prop    = 1'b1;
    gen     = 1'b0;
    group_p = 1'b0;
    group_g = 1'b0;
    for (int i = 0; i < 8; i++) begin
      prop = 1'b1;
      gen  = 1'b0;
      for (int j = i; j >= 0; j--) begin
        gen  = gen | (prop & g[j]);
        prop = prop & p[j];
      end
      c[i+1] = gen | (prop & cin);
      if (i == 7) begin
        group_p = prop;
        group_g = gen;
      end
    end
  end

  assign s    = p ^ c[7:0];
  assign cout = c[8];

endmodule

// File: rtl/cla_pipe_subtractor.sv
// Pipelined 32-bit subtractor: diff = a + ~b + 1, one 8-bit CLA slice per stage,
// with a single global advance so bubbles travel with the data. WIDTH, SLICE_W
// and NSLICE must match the package constants that size the stage registers.
module cla_pipe_subtractor
  import cla_pipe_subtractor_pkg::*;
#(
  parameter int WIDTH   = CLA_WIDTH,
  parameter int SLICE_W = CLA_SLICE_W,
  parameter int NSLICE  = CLA_NSLICE
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             overflow,
  output logic             zero
);

  // Signed overflow of a - b: operands of opposite sign and a result whose
  // sign differs from the minuend.
  function automatic logic sub_overflow(input logic a_msb, input logic b_msb,
                                        input logic d_msb);
    return (a_msb ^ b_msb) & (d_msb ^ a_msb);
  endfunction

  stage_t             st      [NSLICE-1];
  stage_t             st_next [NSLICE-1];
  logic [SLICE_W-1:0] x_in    [NSLICE];
  logic [SLICE_W-1:0] y_in    [NSLICE];
  logic [SLICE_W-1:0] sum     [NSLICE];
  logic [NSLICE-1:0]  c_in;
  logic [NSLICE-1:0]  cout;
  logic [NSLICE-1:0]  grp_p;
  logic [NSLICE-1:0]  grp_g;
  logic [WIDTH-1:0]   b_inv;
  logic [WIDTH-1:0]   diff_next;
  logic               adv;

  // The whole pipe moves only when the output register is empty or draining.
  assign adv      = ~out_valid | out_ready;
  assign in_ready = adv;
  assign b_inv    = ~b;

  // Slice operands: stage 0 reads the ports, later stages read the bytes and
  // carry left by the previous stage.
  always_comb begin
    for (int k = 0; k < NSLICE; k++) begin
      x_in[k] = '0;
      y_in[k] = '0;
    end
    c_in    = '0;
    x_in[0] = a[SLICE_W-1:0];
    y_in[0] = b_inv[SLICE_W-1:0];
    c_in[0] = 1'b1;
    for (int k = 1; k < NSLICE; k++) begin
      x_in[k] = st[k-1].a_rem[SLICE_W-1:0];
      y_in[k] = st[k-1].b_rem[SLICE_W-1:0];
      c_in[k] = st[k-1].carry;
    end
  end

  for (genvar k = 0; k < NSLICE; k++) begin : g_slice
    cla_slice8 u_slice (
      .x       (x_in[k]),
      .y       (y_in[k]),
      .cin     (c_in[k]),
      .s       (sum[k]),
      .cout    (cout[k]),
      .group_p (grp_p[k]),
      .group_g (grp_g[k])
    );
  end

  // Next contents of the internal stages: new byte enters at the top of
  // diff_acc, consumed operand bytes are shifted out.
  always_comb begin
    for (int k = 0; k < NSLICE-1; k++) st_next[k] = '0;
    st_next[0].valid    = in_valid;
    st_next[0].carry    = cout[0];
    st_next[0].diff_acc = {sum[0], {(WIDTH-SLICE_W){1'b0}}};
    st_next[0].a_rem    = a >> SLICE_W;
    st_next[0].b_rem    = b_inv >> SLICE_W;
    st_next[0].a_msb    = a[WIDTH-1];
    st_next[0].b_msb    = b[WIDTH-1];
    for (int k = 1; k < NSLICE-1; k++) begin
      st_next[k].valid    = st[k-1].valid;
      st_next[k].carry    = cout[k];
      st_next[k].diff_acc = {sum[k], (WIDTH-SLICE_W)'(st[k-1].diff_acc >> SLICE_W)};
      st_next[k].a_rem    = st[k-1].a_rem >> SLICE_W;
      st_next[k].b_rem    = st[k-1].b_rem >> SLICE_W;
      st_next[k].a_msb    = st[k-1].a_msb;
      st_next[k].b_msb    = st[k-1].b_msb;
    end
  end

  assign diff_next = {sum[NSLICE-1],
                      (WIDTH-SLICE_W)'(st[NSLICE-2].diff_acc >> SLICE_W)};

  // Internal stage registers, slices 0..NSLICE-2.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NSLICE-1; k++) st[k] <= '0;
    end else if (adv) begin
      for (int k = 0; k < NSLICE-1; k++) st[k] <= st_next[k];
    end
  end

  // Output stage: last slice plus flags; a bubble leaves the previous result
  // in place and only clears out_valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      diff      <= '0;
      borrow    <= 1'b0;
      overflow  <= 1'b0;
      zero      <= 1'b0;
    end else if (adv) begin
      out_valid <= st[NSLICE-2].valid;
      if (st[NSLICE-2].valid) begin
        diff     <= diff_next;
        borrow   <= ~cout[NSLICE-1];
        overflow <= sub_overflow(st[NSLICE-2].a_msb, st[NSLICE-2].b_msb,
                                 diff_next[WIDTH-1]);
        zero     <= ~|diff_next;
      end
    end
  end

endmodule

// File: tb/tb_cla_pipe_subtractor.sv
// Scoreboard bench for cla_pipe_subtractor: directed operand pairs with
// hand-computed results, decoupled monitor, stall and mid-flight reset cases.
module tb_cla_pipe_subtractor;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] diff;
  logic        borrow;
  logic        overflow;
  logic        zero;

  typedef struct {
    logic [31:0] d;
    logic        br;
    logic        ov;
    logic        z;
    int          cyc;
    bit          lat;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cycle  = 0;

  cla_pipe_subtractor dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .borrow    (borrow),
    .overflow  (overflow),
    .zero      (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Present one operand pair and push its expected result when it is accepted.
  task automatic issue(input logic [31:0] av, input logic [31:0] bv,
                       input logic [31:0] ed, input logic eb, input logic eo,
                       input logic ez, input bit lat);
    exp_t e;
    int   waitc;
    waitc    = 0;
    a        = av;
    b        = bv;
    in_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      waitc++;
      if (waitc > 50) begin
        checks++;
        errors++;
        $display("FAIL accept_timeout: in_ready stayed %b for a=%h b=%h", in_ready, av, bv);
        break;
      end
      @(posedge clk);
      #1;
    end
    e.d   = ed;
    e.br  = eb;
    e.ov  = eo;
    e.z   = ez;
    e.cyc = cycle;
    e.lat = lat;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare every output transfer against the head of the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: diff=%h with no operation outstanding", diff);
      end else begin
        e = sb_q.pop_front();
        chk("diff", diff, e.d);
        chk("borrow", 32'(borrow), 32'(e.br));
        chk("overflow", 32'(overflow), 32'(e.ov));
        chk("zero", 32'(zero), 32'(e.z));
        if (e.lat) chk("latency", 32'(cycle - e.cyc), 32'd4);
      end
    end
  end

  initial begin
    exp_t head;
    int   waitc;
    rst_n     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    a         = '0;
    b         = '0;
    #1 rst_n  = 1'b0;
    #1;
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_diff", diff, 32'd0);
    chk("reset_flags", {29'd0, borrow, overflow, zero}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    chk("in_ready_after_reset", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;

    // Basic, borrow chain, signed overflow, then zero + back-to-back stream.
    issue(32'h0000_0005, 32'h0000_0003, 32'h0000_0002, 1'b0, 1'b0, 1'b0, 1'b1);
    issue(32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0, 1'b1);
    issue(32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0, 1'b1);
    issue(32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, 1'b1, 1'b0, 1'b1);
    issue(32'h1234_5678, 32'h1234_5678, 32'h0000_0000, 1'b0, 1'b0, 1'b1, 1'b1);
    issue(32'h0000_0010, 32'h0000_0001, 32'h0000_000F, 1'b0, 1'b0, 1'b0, 1'b1);
    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1'b0, 1'b1, 1'b1);
    issue(32'h0000_0100, 32'h0000_0001, 32'h0000_00FF, 1'b0, 1'b0, 1'b0, 1'b1);
    issue(32'h0001_0000, 32'h0000_0001, 32'h0000_FFFF, 1'b0, 1'b0, 1'b0, 1'b1);
    issue(32'h0100_0000, 32'h0000_0001, 32'h00FF_FFFF, 1'b0, 1'b0, 1'b0, 1'b1);
    issue(32'h0000_0001, 32'h0000_0002, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0, 1'b1);
    issue(32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 1'b0, 1'b0, 1'b1, 1'b1);
    issue(32'h8000_0000, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b1, 1'b0, 1'b1);
    issue(32'hDEAD_BEEF, 32'h1234_5678, 32'hCC79_6877, 1'b0, 1'b0, 1'b0, 1'b1);
    issue(32'h1234_5678, 32'hDEAD_BEEF, 32'h3386_9789, 1'b1, 1'b0, 1'b0, 1'b1);
    in_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1;

    // Backpressure: six ops, then stall the output for three edges.
    issue(32'h0000_0064, 32'h0000_0032, 32'h0000_0032, 1'b0, 1'b0, 1'b0, 1'b0);
    issue(32'h0000_0003, 32'h0000_0005, 32'hFFFF_FFFE, 1'b1, 1'b0, 1'b0, 1'b0);
    issue(32'hAAAA_AAAA, 32'h5555_5555, 32'h5555_5555, 1'b0, 1'b1, 1'b0, 1'b0);
    issue(32'h5555_5555, 32'hAAAA_AAAA, 32'hAAAA_AAAB, 1'b1, 1'b1, 1'b0, 1'b0);
    issue(32'h0000_FFFF, 32'h0000_FFFF, 32'h0000_0000, 1'b0, 1'b0, 1'b1, 1'b0);
    issue(32'h0000_0000, 32'h8000_0000, 32'h8000_0000, 1'b1, 1'b1, 1'b0, 1'b0);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL stall_queue: scoreboard empty during stall, expected 4 entries");
      end else begin
        head = sb_q[0];
        chk("stall_in_ready", 32'(in_ready), 32'd0);
        chk("stall_out_valid", 32'(out_valid), 32'd1);
        chk("stall_diff", diff, head.d);
        chk("stall_flags", {29'd0, borrow, overflow, zero}, {29'd0, head.br, head.ov, head.z});
      end
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    chk("stall_drained", 32'(sb_q.size()), 32'd0);

    // Reset mid-flight: three accepted ops must vanish.
    issue(32'h0000_0011, 32'h0000_0001, 32'h0000_0010, 1'b0, 1'b0, 1'b0, 1'b1);
    issue(32'h0000_0022, 32'h0000_0002, 32'h0000_0020, 1'b0, 1'b0, 1'b0, 1'b1);
    issue(32'h0000_0033, 32'h0000_0003, 32'h0000_0030, 1'b0, 1'b0, 1'b0, 1'b1);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("midreset_out_valid", 32'(out_valid), 32'd0);
    chk("midreset_diff", diff, 32'd0);
    chk("midreset_flags", {29'd0, borrow, overflow, zero}, 32'd0);
    sb_q.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    issue(32'h0000_0009, 32'h0000_0004, 32'h0000_0005, 1'b0, 1'b0, 1'b0, 1'b1);
    in_valid = 1'b0;

    waitc = 0;
    while (sb_q.size() != 0 && waitc < 50) begin
      @(posedge clk);
      waitc++;
    end
    #1;
    chk("final_drained", 32'(sb_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
